view_vector_loader: RTL and testbench
=====================================

Name: view_vector_loader

Overview:
- Upstream stage of the raybox-zero top level. It receives the six view vectors over a slow external SPI link and double-buffers them.
- The vectors are playerX/Y, facingX/Y and vplaneX/Y.
- It presents stable vectors to the wall tracer and debug/map overlays, committing a new set only on the load strobe at the visible frame end. This avoids tearing mid-frame.

Parameters:
- FW, 16, fixed-point word width (signed, 7 integer + 9 fraction bits, matching the shared `F format).
- NVEC, 6, number of vectors per SPI frame; frame payload is NVEC*FW = 96 bits.

Ports:
- clk  in  1  pixel clock (25 MHz class).
- reset  in  1  asynchronous, active-high reset.
- i_sclk  in  1  SPI clock, asynchronous to clk, mode 0; max frequency clk/4.
- i_mosi  in  1  SPI data, MSB first.
- i_ss_n  in  1  SPI select, active-low, frames one vector set.
- load_if_ready  in  1  one-clk strobe (hpos==799 && vpos==479); commits pending set if one is ready.
- playerX, playerY, facingX, facingY, vplaneX, vplaneY  out  FW each  live vectors (registered).
- o_ready  out  1  a complete, uncommitted vector set is pending.
- o_frame_err  out  1  one-clk pulse when a frame ends with a bit count other than 96.

Behaviour:
- Reset: asynchronous, active-high, applies to all flops.
  - Reset values in Q7.9: playerX=0x0300 (1.5), playerY=0x0300, facingX=0x0000, facingY=0x0200 (1.0), vplaneX=0xFF00 (-0.5), vplaneY=0x0000.
  - pending=0, o_ready=0, o_frame_err=0, FSM=IDLE.
- Synchronisation:
  - i_sclk, i_mosi and i_ss_n each pass through 2-flop synchronisers; sclk and ss_n get a third flop for edge detection.
  - All SPI sampling is in the clk domain.
- FSM:
  - IDLE: on synchronised ss_n falling edge, go to SHIFT; clear bit counter (7-bit) and overflow flag.
  - SHIFT: on each synchronised sclk rising edge, shift mosi into the LSB of a 96-bit shift register.
    - Counter increments, saturating at 97; reaching 97 sets overflow.
    - On ss_n rising edge, go to DONE.
  - DONE (one cycle): if count==96 and no overflow, copy the shift register into pending and set o_ready. Otherwise pulse o_frame_err and leave pending and o_ready unchanged. Then go to IDLE.
- Bit order and packing: the first bit received is playerX[15]. Word order is playerX, playerY, facingX, facingY, vplaneX, vplaneY. Pending bits [95:80] map to playerX.
- Commit: when load_if_ready is high and o_ready is high, copy pending to the live outputs (visible next cycle) and clear o_ready. When o_ready is low, load_if_ready has no effect.
- Simultaneous load_if_ready and DONE-success in the same cycle:
  - Live outputs take the old pending.
  - pending takes the new frame.
  - o_ready ends high (set wins over clear).
- A new frame while o_ready=1 overwrites pending; the latest complete frame wins.
- ss_n rising edge in IDLE is ignored. An sclk edge with ss_n high is ignored.
- ss_n glitching low→high before any sclk edge gives count 0 → o_frame_err.
- Latency: ss_n rising at the pin → o_ready high within 5 clk (sync 2 + edge 1 + DONE 1 + reg 1).
- Live outputs never change except at reset or on a commit.

Decomposition:
- Shared package/include (fixed_point_params): the `F width macro, FW, and the reset-default vector constants.
- One natural sub-module: spi_frame_rx, containing the synchronisers, FSM, counter and shift register. It outputs frame_done, frame_ok and the 96-bit data.
- The parent holds pending, o_ready and the live registers.

Test Plan:
- Reset mid-frame: assert reset after 40 bits → all outputs return to defaults (playerX=0x0300, vplaneX=0xFF00); o_ready=0. The next full frame is accepted normally.
- Clean frame then commit:
  - Send 96 bits 0x0480_0280_0100_FF00_0000_0080 at sclk=clk/4 → o_ready=1 within 5 clk of ss_n high; outputs unchanged.
  - Then pulse load_if_ready → next cycle playerX=0x0480, facingZ fields as packed (facingX=0x0100, facingY=0xFF00, vplaneY=0x0080); o_ready=0.
- Bad lengths: a 95-bit frame and a 97-bit frame → one o_frame_err pulse each; o_ready stays 0; outputs unchanged.
- Load without data: pulse load_if_ready with o_ready=0 → outputs hold reset values.
- Overwrite: send frame A then frame B before any load, then load → outputs equal B.
- Collision: align DONE of frame B with load_if_ready while A is pending → outputs=A, o_ready=1; the following load yields B.

Source files
------------

// File: rtl/view_vector_loader_pkg.sv
// Shared fixed-point widths, frame geometry and reset-default view vectors.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package view_vector_loader_pkg;

  // Q7.9 signed fixed-point word.
  localparam int FW         = 16;
  localparam int NVEC       = 6;
  localparam int FRAME_BITS = NVEC * FW;

  // The bit counter is 7 bits wide. It saturates one past a full frame so that
  // an over-long frame can never alias back to a legal count.
  localparam int             CNT_W     = 7;
  localparam logic [CNT_W-1:0] CNT_FRAME = 7'd96;
  localparam logic [CNT_W-1:0] CNT_SAT   = 7'd97;

  // Power-on view: standing at (1.5, 1.5), facing +Y, with a half-width camera plane.
  localparam logic [FW-1:0] PLAYER_X_RST = 16'h0300;
  localparam logic [FW-1:0] PLAYER_Y_RST = 16'h0300;
  localparam logic [FW-1:0] FACING_X_RST = 16'h0000;
  localparam logic [FW-1:0] FACING_Y_RST = 16'h0200;
  localparam logic [FW-1:0] VPLANE_X_RST = 16'hFF00;
  localparam logic [FW-1:0] VPLANE_Y_RST = 16'h0000;

  // Live registers use the same packing as the SPI frame: playerX in the top word.
  localparam logic [FRAME_BITS-1:0] LIVE_RST = {PLAYER_X_RST, PLAYER_Y_RST,
                                                FACING_X_RST, FACING_Y_RST,
                                                VPLANE_X_RST, VPLANE_Y_RST};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/view_vector_loader_if.sv
// SPI pin bundle carrying one vector set per select-low frame.
// Latency: n/a (wires only).
// Backpressure: none; the SPI master free-runs and the receiver must keep up.
interface view_vector_loader_if;
  logic i_sclk;
  logic i_mosi;
  logic i_ss_n;

  modport master (output i_sclk, output i_mosi, output i_ss_n);
  modport slave  (input  i_sclk, input  i_mosi, input  i_ss_n);
endinterface

// File: rtl/view_vector_loader_spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises pins into clk, shifts bits, judges frame length.
// Latency: frame_done asserts 3 clk after the ss_n rising edge reaches the pin.
// Backpressure: none; frame_done/frame_ok are single-cycle and must be consumed at once.
module view_vector_loader_spi_frame_rx
  import view_vector_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss_n,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [FRAME_BITS-1:0] frame_dat
);

  // Index 0 is the first synchroniser stage, 1 the settled value, 2 the edge-detect history.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] ss_sync_q,   ss_sync_d;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   ovf_q,   ovf_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;

  logic sclk_rise;
  logic ss_fall;
  logic ss_rise;

  // Synchroniser chains advance one stage per clk.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
    mosi_sync_d = {mosi_sync_q[0],   i_mosi};
    ss_sync_d   = {ss_sync_q[1:0],   i_ss_n};
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
  assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];

  // Next-state, bit shifting/counting and the one-cycle frame verdict.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_sync_q[1]};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 7'd1;
          end
          if (cnt_q == CNT_SAT - 7'd1) begin
            ovf_d = 1'b1;
          end
        end
        if (ss_rise) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        frame_ok   = (cnt_q == CNT_FRAME) && !ovf_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and synchroniser registers; ss_n resets high so no false select edge follows reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 3'b111;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      shreg_q     <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      shreg_q     <= shreg_d;
    end
  end

  assign frame_dat = shreg_q;

endmodule

// File: rtl/view_vector_loader.sv
// Double-buffered view vector loader: SPI frame -> pending set -> live set on frame-end strobe.
// Latency: ss_n rising at the pin -> o_ready high after 4 clk; commit visible 1 clk after load_if_ready.
// Backpressure: none; a newer complete frame overwrites an uncommitted pending set.
module view_vector_loader
  import view_vector_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  view_vector_loader_if.slave  spi,
  input  logic                 load_if_ready,
  output logic [FW-1:0]        playerX,
  output logic [FW-1:0]        playerY,
  output logic [FW-1:0]        facingX,
  output logic [FW-1:0]        facingY,
  output logic [FW-1:0]        vplaneX,
  output logic [FW-1:0]        vplaneY,
  output logic                 o_ready,
  output logic                 o_frame_err
);

  logic                  frame_done;
  logic                  frame_ok;
  logic [FRAME_BITS-1:0] frame_dat;

  logic [FRAME_BITS-1:0] pending_q, pending_d;
  logic [FRAME_BITS-1:0] live_q,    live_d;
  logic                  ready_q,   ready_d;
  logic                  err_q,     err_d;
  logic                  commit;

  view_vector_loader_spi_frame_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_sclk     (spi.i_sclk),
    .i_mosi     (spi.i_mosi),
    .i_ss_n     (spi.i_ss_n),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_dat  (frame_dat)
  );

  assign commit = load_if_ready && ready_q;

  // Commit takes the pending set as it stood this cycle, so a frame landing in the
  // same cycle becomes the next pending set and re-arms o_ready (set beats clear).
  always_comb begin
    live_d    = live_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    if (commit) begin
      live_d  = pending_q;
      ready_d = 1'b0;
    end
    if (frame_done) begin
      if (frame_ok) begin
        pending_d = frame_dat;
        ready_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Buffer and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q    <= LIVE_RST;
      pending_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      live_q    <= live_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign playerX     = live_q[6*FW-1:5*FW];
  assign playerY     = live_q[5*FW-1:4*FW];
  assign facingX     = live_q[4*FW-1:3*FW];
  assign facingY     = live_q[3*FW-1:2*FW];
  assign vplaneX     = live_q[2*FW-1:1*FW];
  assign vplaneY     = live_q[1*FW-1:0];
  assign o_ready     = ready_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_view_vector_loader.sv
// Self-checking bench for view_vector_loader: scripted table, corner sequences, random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_view_vector_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_if_ready;
  logic [15:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic        o_ready;
  logic        o_frame_err;

  view_vector_loader_if spi_bus ();

  view_vector_loader dut (
    .clk           (clk),
    .reset         (reset),
    .spi           (spi_bus),
    .load_if_ready (load_if_ready),
    .playerX       (playerX),
    .playerY       (playerY),
    .facingX       (facingX),
    .facingY       (facingY),
    .vplaneX       (vplaneX),
    .vplaneY       (vplaneY),
    .o_ready       (o_ready),
    .o_frame_err   (o_frame_err)
  );

  always #20 clk = ~clk;

  localparam logic [95:0] DEF = 96'h0300_0300_0000_0200_FF00_0000;
  localparam logic [95:0] D1  = 96'h0480_0280_0100_FF00_0000_0080;
  localparam logic [95:0] FA  = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [95:0] FB  = 96'hABCD_0123_4567_89AB_CDEF_FEDC;

  int checks = 0;
  int errors = 0;

  // Reference model: six live words, six pending words, one ready flag.
  logic [15:0] m_live [6];
  logic [15:0] m_pend [6];
  bit          m_ready;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] dut_live();
    return {playerX, playerY, facingX, facingY, vplaneX, vplaneY};
  endfunction

  function automatic logic [95:0] model_live();
    logic [95:0] r;
    for (int w = 0; w < 6; w++) r[95-16*w -: 16] = m_live[w];
    return r;
  endfunction

  task automatic model_reset();
    logic [95:0] d;
    d = DEF;
    for (int w = 0; w < 6; w++) begin
      m_live[w] = d[95-16*w -: 16];
      m_pend[w] = 16'h0000;
    end
    m_ready = 0;
  endtask

  // Only an exact 96-bit frame is accepted; anything else is an error.
  function automatic int model_frame(input logic [95:0] d, input int n);
    if (n == 96) begin
      for (int w = 0; w < 6; w++) m_pend[w] = d[95-16*w -: 16];
      m_ready = 1;
      return 0;
    end
    return 1;
  endfunction

  task automatic model_load();
    if (m_ready) begin
      for (int w = 0; w < 6; w++) m_live[w] = m_pend[w];
      m_ready = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI bit at sclk = clk/4: data set while sclk low, sampled on the rise.
  task automatic send_bit(input logic b);
    spi_bus.i_mosi = b;
    spi_bus.i_sclk = 1'b0;
    tick(); tick();
    spi_bus.i_sclk = 1'b1;
    tick(); tick();
    spi_bus.i_sclk = 1'b0;
  endtask

  task automatic frame_body(input logic [127:0] v, input int n);
    spi_bus.i_ss_n = 1'b0;
    spi_bus.i_sclk = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < n; i++) send_bit(v[n-1-i]);
    tick(); tick();
  endtask

  // Full frame; afterwards watch 8 clk for error pulses and the o_ready rise.
  task automatic run_frame(input logic [127:0] v, input int n, output int err_cnt, output int rdy_cyc);
    bit rb;
    frame_body(v, n);
    rb = o_ready;
    spi_bus.i_ss_n = 1'b1;
    err_cnt = 0;
    rdy_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (o_frame_err) err_cnt++;
      if (!rb && o_ready && rdy_cyc == 0) rdy_cyc = c;
    end
  endtask

  task automatic load_pulse();
    load_if_ready = 1'b1;
    tick();
    load_if_ready = 1'b0;
    tick();
  endtask

  typedef struct {
    int          nbits;    // -1: no frame this row
    logic [95:0] dat;
    bit          load;
    int          exp_err;
    bit          exp_ready;
    logic [95:0] exp_live;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ec, rc, n, op, exp_err;
    bit ready_before;
    logic [95:0] rd;

    tbl[0] = '{-1, 96'h0, 1, 0, 0, DEF};  // load with nothing pending
    tbl[1] = '{96, D1,    0, 0, 1, DEF};  // clean frame, outputs unchanged
    tbl[2] = '{-1, 96'h0, 1, 0, 0, D1};   // commit
    tbl[3] = '{95, FA,    0, 1, 0, D1};   // short frame
    tbl[4] = '{97, FA,    0, 1, 0, D1};   // long frame
    tbl[5] = '{0,  FA,    0, 1, 0, D1};   // select glitch, zero bits
    tbl[6] = '{96, FA,    0, 0, 1, D1};   // frame A pending
    tbl[7] = '{96, FB,    1, 0, 0, FB};   // frame B overwrites A, then commit

    reset          = 1'b1;
    load_if_ready  = 1'b0;
    spi_bus.i_ss_n = 1'b1;
    spi_bus.i_sclk = 1'b0;
    spi_bus.i_mosi = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_playerX", playerX, 16'h0300);
    check("rst_playerY", playerY, 16'h0300);
    check("rst_facingX", facingX, 16'h0000);
    check("rst_facingY", facingY, 16'h0200);
    check("rst_vplaneX", vplaneX, 16'hFF00);
    check("rst_vplaneY", vplaneY, 16'h0000);
    check("rst_ready",   o_ready, 1'b0);
    check("rst_err",     o_frame_err, 1'b0);
    reset = 1'b0;
    tick();

    // Scripted table.
    for (int i = 0; i < 8; i++) begin
      ready_before = m_ready;
      if (tbl[i].nbits >= 0) begin
        run_frame({32'h0, tbl[i].dat}, tbl[i].nbits, ec, rc);
        exp_err = model_frame(tbl[i].dat, tbl[i].nbits);
        check($sformatf("row%0d_err", i), ec, tbl[i].exp_err);
        if (tbl[i].nbits == 96 && !ready_before)
          check($sformatf("row%0d_latency_le5", i), (rc >= 1 && rc <= 5), 1'b1);
      end
      if (tbl[i].load) begin
        load_pulse();
        model_load();
      end
      check($sformatf("row%0d_ready", i), o_ready, tbl[i].exp_ready);
      check($sformatf("row%0d_live", i), dut_live(), tbl[i].exp_live);
    end

    // Reset in the middle of a frame (40 bits in).
    spi_bus.i_ss_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 40; i++) send_bit(FB[95-i]);
    reset          = 1'b1;
    spi_bus.i_ss_n = 1'b1;
    spi_bus.i_sclk = 1'b0;
    tick();
    check("midrst_live",  dut_live(), DEF);
    check("midrst_ready", o_ready, 1'b0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    run_frame({32'h0, FA}, 96, ec, rc);
    exp_err = model_frame(FA, 96);
    check("midrst_next_err",   ec, 0);
    check("midrst_next_ready", o_ready, 1'b1);
    check("midrst_next_live",  dut_live(), DEF);
    load_pulse();
    model_load();
    check("midrst_commit_live", dut_live(), FA);

    // Collision: load strobe lands in the same cycle frame B completes, with A pending.
    run_frame({32'h0, FA}, 96, ec, rc);
    exp_err = model_frame(FA, 96);
    check("coll_a_ready", o_ready, 1'b1);
    frame_body({32'h0, FB}, 96);
    spi_bus.i_ss_n = 1'b1;
    tick(); tick(); tick();
    load_if_ready = 1'b1;
    tick();
    load_if_ready = 1'b0;
    model_load();
    exp_err = model_frame(FB, 96);
    check("coll_live_is_a", dut_live(), FA);
    check("coll_ready",     o_ready, 1'b1);
    tick();
    load_pulse();
    model_load();
    check("coll_next_live", dut_live(), FB);
    check("coll_next_ready", o_ready, 1'b0);

    // Randomised frames and loads against the model.
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        load_pulse();
        model_load();
      end else begin
        rd = {$urandom(), $urandom(), $urandom()};
        n  = ($urandom_range(0, 3) == 0) ? $urandom_range(93, 99) : 96;
        run_frame({32'h0, rd}, n, ec, rc);
        exp_err = model_frame(rd, n);
        check($sformatf("rnd%0d_err", it), ec, exp_err);
      end
      check($sformatf("rnd%0d_ready", it), o_ready, m_ready);
      check($sformatf("rnd%0d_live", it), dut_live(), model_live());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
